pre_if_stage: RTL and testbench

Pre-IF stage and PI→IF pipeline register of the LoongArch in-order pipeline. Generates the next fetch PC (sequential +4 or branch redirect) and drives the synchronous instruction SRAM. It holds the IF-stage PC and valid bit, which feed the IF stage over `pi_to_ibus` / `if_valid_i` under the valid/allowin handshake.

---
 rtl/pre_if_stage_pkg.sv | 27 ++
 rtl/pre_if_stage_npc_sel.sv | 32 +++
 rtl/pre_if_stage.sv | 94 +++++++++
 tb/tb_pre_if_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pre_if_stage_pkg.sv
// Shared definitions for the pre-IF stage: PC width, PI->IF bus width,
// reset PC value and the next-PC source selection.
package pre_if_stage_pkg;

    localparam int          PcWidth        = 32;
    localparam int          PiToIfBusWidth = PcWidth;
    localparam logic [31:0] RESET_PC_VAL   = 32'h1C00_0000;
    localparam int          PcStep         = 4;

    // Where the next fetch address comes from
    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,   // sequential pc + 4
        NPC_BUF = 2'd1,   // previously buffered redirect
        NPC_BR  = 2'd2    // redirect presented this cycle
    } npc_src_e;

    // A live redirect beats a buffered one, which beats sequential flow
    function automatic npc_src_e npc_src(input logic br_taken, input logic buf_valid);
        if (br_taken)
            return NPC_BR;
        else if (buf_valid)
            return NPC_BUF;
        else
            return NPC_SEQ;
    endfunction

endpackage

// File: rtl/pre_if_stage_npc_sel.sv
// Next-PC selection for the pre-IF stage: redirect mux plus the +4 adder.
// Purely combinational; all state lives in pre_if_stage.
module pre_if_stage_npc_sel
    import pre_if_stage_pkg::*;
#(
    parameter int PC_W = PcWidth
) (
    input  logic [PC_W-1:0] i_pc,
    input  logic            i_br_taken,
    input  logic [PC_W-1:0] i_br_target,
    input  logic            i_buf_valid,
    input  logic [PC_W-1:0] i_buf_target,
    output logic [PC_W-1:0] o_nextpc
);

    logic [PC_W-1:0] w_seq_pc;

    // The sum wraps naturally modulo 2^PC_W
    assign w_seq_pc = i_pc + PC_W'(PcStep);

    // Pick the next fetch address by redirect priority
    always_comb begin
        // NOTE: default first so every path assigns the output and no latch is inferred.
        o_nextpc = w_seq_pc;
        case (npc_src(i_br_taken, i_buf_valid))
            NPC_BR:  o_nextpc = i_br_target;
            NPC_BUF: o_nextpc = i_buf_target;
            default: o_nextpc = w_seq_pc;
        endcase
    end

endmodule

// File: rtl/pre_if_stage.sv
// Pre-IF stage and PI->IF pipeline register. Generates the next fetch PC,
// drives the synchronous instruction SRAM, and holds the IF-stage PC/valid.
// Build option: define PIF_BR_BUF_EN to add the pending-redirect buffer;
// without it the redirect sender holds br_taken_i/br_target_i until fire.
module pre_if_stage
    import pre_if_stage_pkg::*;
#(
    parameter int              PC_W     = PcWidth,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_VAL)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_allowin_i,
    input  logic            br_taken_i,
    input  logic [PC_W-1:0] br_target_i,
    output logic            if_valid_o,
    output logic [PC_W-1:0] pi_to_ibus_o,
    output logic            inst_sram_en_o,
    output logic [PC_W-1:0] inst_sram_addr_o
);

    logic [PC_W-1:0] r_pc;
    logic            r_if_valid;
    logic            r_pi_valid;

    logic            w_fire;
    logic [PC_W-1:0] w_nextpc;
    logic            w_buf_valid;
    logic [PC_W-1:0] w_buf_target;

    // The stage advances only when pre-IF has a request and IF can take it
    assign w_fire = r_pi_valid && if_allowin_i;

    pre_if_stage_npc_sel #(
        .PC_W (PC_W)
    ) u_npc_sel (
        .i_pc         (r_pc),
        .i_br_taken   (br_taken_i),
        .i_br_target  (br_target_i),
        .i_buf_valid  (w_buf_valid),
        .i_buf_target (w_buf_target),
        .o_nextpc     (w_nextpc)
    );

    // IF-stage PC/valid register and the pre-IF request flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
            r_pc       <= RESET_PC - PC_W'(PcStep);
            r_if_valid <= 1'b0;
            r_pi_valid <= 1'b0;
        end else begin
            r_pi_valid <= 1'b1;
            if (w_fire) begin
                r_pc       <= w_nextpc;
                r_if_valid <= 1'b1;
            end else if (br_taken_i || if_allowin_i) begin
                // A redirect kills the IF entry; an empty pre-IF drains it
                r_if_valid <= 1'b0;
            end
        end
    end

`ifdef PIF_BR_BUF_EN
    logic            r_buf_valid;
    logic [PC_W-1:0] r_buf_target;

    // Remember a redirect that arrived without fire; latest one wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_valid  <= 1'b0;
            r_buf_target <= '0;
        end else if (w_fire) begin
            r_buf_valid  <= 1'b0;
        end else if (br_taken_i) begin
            r_buf_valid  <= 1'b1;
            r_buf_target <= br_target_i;
        end
    end

    assign w_buf_valid  = r_buf_valid;
    assign w_buf_target = r_buf_target;
`else
    // No buffer: the sender keeps the redirect asserted until it fires
    assign w_buf_valid  = 1'b0;
    assign w_buf_target = '0;
`endif

    assign if_valid_o       = r_if_valid;
    assign pi_to_ibus_o     = r_pc;
    assign inst_sram_en_o   = w_fire;
    assign inst_sram_addr_o = w_nextpc;

endmodule

// File: tb/tb_pre_if_stage.sv
// Self-checking bench for pre_if_stage: directed vector table, hand-written
// multi-cycle sequences (buffered redirect, wrap, async reset) and a
// randomized run checked against a behavioural model.
module tb_pre_if_stage;

    localparam logic [31:0] RST_PC = 32'h1C00_0000;

    logic        clk;
    logic        rst;
    logic        if_allowin_i;
    logic        br_taken_i;
    logic [31:0] br_target_i;
    logic        if_valid_o;
    logic [31:0] pi_to_ibus_o;
    logic        inst_sram_en_o;
    logic [31:0] inst_sram_addr_o;

    int n_checks = 0;
    int n_pass   = 0;

    pre_if_stage dut (
        .clk              (clk),
        .rst              (rst),
        .if_allowin_i     (if_allowin_i),
        .br_taken_i       (br_taken_i),
        .br_target_i      (br_target_i),
        .if_valid_o       (if_valid_o),
        .pi_to_ibus_o     (pi_to_ibus_o),
        .inst_sram_en_o   (inst_sram_en_o),
        .inst_sram_addr_o (inst_sram_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // ---------------- behavioural reference model ----------------
    // The IF entry is an address plus a valid flag; pending redirects are a
    // queue that only ever holds the most recent target.
    logic [31:0] m_pc;
    logic        m_if_valid;
    logic        m_pi_valid;
    logic [31:0] m_redir[$];

    function automatic void model_reset();
        m_pc       = RST_PC - 32'd4;
        m_if_valid = 1'b0;
        m_pi_valid = 1'b0;
        m_redir.delete();
    endfunction

    function automatic logic [31:0] model_nextpc(input logic br, input logic [31:0] tgt);
        if (br)                  return tgt;
        if (m_redir.size() != 0) return m_redir[0];
        return m_pc + 32'd4;
    endfunction

    function automatic void model_step(input logic al, input logic br, input logic [31:0] tgt);
        logic fire;
        fire = m_pi_valid && al;
        if (fire) begin
            m_pc       = model_nextpc(br, tgt);
            m_if_valid = 1'b1;
            m_redir.delete();
        end else if (br) begin
            m_if_valid = 1'b0;
`ifdef PIF_BR_BUF_EN
            m_redir.delete();
            m_redir.push_back(tgt);
`endif
        end else if (al) begin
            m_if_valid = 1'b0;
        end
        m_pi_valid = 1'b1;
    endfunction

    task automatic model_check(input string tag);
        check({tag, "_en"},    32'(inst_sram_en_o),  32'(m_pi_valid && if_allowin_i));
        check({tag, "_addr"},  inst_sram_addr_o,     model_nextpc(br_taken_i, br_target_i));
        check({tag, "_valid"}, 32'(if_valid_o),      32'(m_if_valid));
        check({tag, "_pc"},    pi_to_ibus_o,         m_pc);
    endtask

    // Drive inputs just after a falling edge and let them settle
    task automatic apply(input logic al, input logic br, input logic [31:0] tgt);
        if_allowin_i = al;
        br_taken_i   = br;
        br_target_i  = tgt;
        #1;
    endtask

    // Take one rising edge, keeping the model in step, and return to a falling edge
    task automatic advance();
        model_step(if_allowin_i, br_taken_i, br_target_i);
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        al;
        logic        br;
        logic [31:0] tgt;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_en;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic        hold;
        logic [31:0] held_tgt;
        logic        al;
        logic        br;
        logic [31:0] tgt;

        //            al    br    tgt           valid pc            en    addr
        vecs[0]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h1BFF_FFFC, 1'b0, 32'h1C00_0000};
        vecs[1]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h1BFF_FFFC, 1'b1, 32'h1C00_0000};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h1C00_0000, 1'b1, 32'h1C00_0004};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h1C00_0004, 1'b1, 32'h1C00_0008};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h1C00_0008, 1'b0, 32'h1C00_000C};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h1C00_0008, 1'b0, 32'h1C00_000C};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h1C00_0008, 1'b0, 32'h1C00_000C};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h1C00_0008, 1'b1, 32'h1C00_000C};
        vecs[8]  = '{1'b1, 1'b1, 32'h1C00_0100, 1'b1, 32'h1C00_000C, 1'b1, 32'h1C00_0100};
        vecs[9]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h1C00_0100, 1'b1, 32'h1C00_0104};
        vecs[10] = '{1'b0, 1'b1, 32'h1C00_0400, 1'b1, 32'h1C00_0104, 1'b0, 32'h1C00_0400};
        vecs[11] = '{1'b1, 1'b1, 32'h1C00_0400, 1'b0, 32'h1C00_0104, 1'b1, 32'h1C00_0400};
        vecs[12] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h1C00_0400, 1'b1, 32'h1C00_0404};

        rst = 1'b1;
        if_allowin_i = 1'b1;
        br_taken_i   = 1'b0;
        br_target_i  = 32'h0;
        model_reset();

        // Reset state
        @(negedge clk);
        #1;
        check("rst_valid", 32'(if_valid_o),     32'h0);
        check("rst_pc",    pi_to_ibus_o,        32'h1BFF_FFFC);
        check("rst_en",    32'(inst_sram_en_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Table: reset release, stall, redirect with fire, held redirect without fire
        for (int i = 0; i < 13; i++) begin
            apply(vecs[i].al, vecs[i].br, vecs[i].tgt);
            check($sformatf("vec%0d_valid", i), 32'(if_valid_o),     32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_pc", i),    pi_to_ibus_o,        vecs[i].exp_pc);
            check($sformatf("vec%0d_en", i),    32'(inst_sram_en_o), 32'(vecs[i].exp_en));
            check($sformatf("vec%0d_addr", i),  inst_sram_addr_o,    vecs[i].exp_addr);
            advance();
        end

`ifdef PIF_BR_BUF_EN
        // Branch during stall is buffered and fetched on the next fire
        apply(1'b0, 1'b1, 32'h1C00_0200);
        check("buf_br_en", 32'(inst_sram_en_o), 32'h0);
        advance();
        check("buf_kill_valid", 32'(if_valid_o), 32'h0);
        apply(1'b0, 1'b0, 32'h0);
        check("buf_hold_addr", inst_sram_addr_o, 32'h1C00_0200);
        advance();
        apply(1'b1, 1'b0, 32'h0);
        check("buf_fire_en",   32'(inst_sram_en_o), 32'h1);
        check("buf_fire_addr", inst_sram_addr_o,    32'h1C00_0200);
        advance();
        check("buf_fetch_pc",    pi_to_ibus_o,     32'h1C00_0200);
        check("buf_fetch_valid", 32'(if_valid_o),  32'h1);
        // Second redirect while buffered overwrites the first
        apply(1'b0, 1'b1, 32'h1C00_0250);
        advance();
        apply(1'b0, 1'b1, 32'h1C00_0300);
        advance();
        apply(1'b1, 1'b0, 32'h0);
        check("buf_latest_addr", inst_sram_addr_o, 32'h1C00_0300);
        advance();
        check("buf_latest_pc", pi_to_ibus_o, 32'h1C00_0300);
`endif

        // PC wraps from the top of the address space to zero
        apply(1'b1, 1'b1, 32'hFFFF_FFFC);
        advance();
        check("wrap_top_pc", pi_to_ibus_o, 32'hFFFF_FFFC);
        apply(1'b1, 1'b0, 32'h0);
        check("wrap_addr", inst_sram_addr_o, 32'h0000_0000);
        advance();
        check("wrap_pc", pi_to_ibus_o, 32'h0000_0000);

        // Asynchronous reset mid-stream, with a redirect pending when buffered
        apply(1'b0, 1'b1, 32'h1C00_0500);
        advance();
        apply(1'b0, 1'b0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_valid", 32'(if_valid_o),     32'h0);
        check("arst_pc",    pi_to_ibus_o,        32'h1BFF_FFFC);
        check("arst_en",    32'(inst_sram_en_o), 32'h0);
        check("arst_addr",  inst_sram_addr_o,    RST_PC);
        @(negedge clk);
        rst = 1'b0;
        apply(1'b1, 1'b0, 32'h0);
        advance();
        apply(1'b1, 1'b0, 32'h0);
        check("restart_addr", inst_sram_addr_o, RST_PC);
        advance();
        check("restart_pc",    pi_to_ibus_o,    RST_PC);
        check("restart_valid", 32'(if_valid_o), 32'h1);

        // Randomized run against the model
        hold     = 1'b0;
        held_tgt = 32'h0;
        for (int i = 0; i < 400; i++) begin
            if (hold) begin
                br  = 1'b1;
                tgt = held_tgt;
            end else begin
                br  = ($urandom_range(0, 5) == 0);
                tgt = $urandom & 32'hFFFF_FFFC;
            end
            al = ($urandom_range(0, 3) != 0);
            apply(al, br, tgt);
            model_check("rand");
`ifdef PIF_BR_BUF_EN
            hold = br && !(m_pi_valid && al) && ($urandom_range(0, 1) == 1);
`else
            hold = br && !(m_pi_valid && al);
`endif
            held_tgt = tgt;
            advance();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
